// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the row and column passes of the 2-D binDCT.
// Rows are written into one bank while the other bank is read out column by column.
module dct_transpose_buf #(
  parameter int W_D = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [7:0][W_D-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [7:0][W_D-1:0]  out_data,
  output logic [2:0]                  out_col,
  output logic                        out_last
);

  logic [1:0][7:0][7:0][W_D-1:0] mem;
  logic       wr_bank;
  logic [2:0] wr_row;
  logic       rd_bank;
  logic [2:0] rd_col;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_fire;
  logic       rd_fire;

  // Handshakes depend on registered state only, so in_ready never sees out_ready.
  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_col   = rd_col;
  assign out_last  = out_valid && (rd_col == 3'd7);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Column mux straight off the storage registers of the bank being read.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < 8; i++) begin
      out_data[i] = mem[rd_bank][i][rd_col];
    end
  end

  // Bank occupancy: a write and a read can only ever touch different banks in one cycle.
  always_comb begin
    full_nxt = full;
    if (wr_fire && (wr_row == 3'd7)) begin
      full_nxt[wr_bank] = 1'b1;
    end else begin
      full_nxt = full_nxt;
    end
    if (rd_fire && (rd_col == 3'd7)) begin
      full_nxt[rd_bank] = 1'b0;
    end else begin
      full_nxt = full_nxt;
    end
  end

  // Row storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (wr_fire) begin
      mem[wr_bank][wr_row] <= in_data;
    end
  end

  // Write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_row  <= 3'd0;
    end else if (wr_fire) begin
      if (wr_row == 3'd7) begin
        wr_bank <= ~wr_bank;
        wr_row  <= 3'd0;
      end else begin
        wr_row  <= wr_row + 3'd1;
      end
    end
  end

  // Read pointer and occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      rd_col  <= 3'd0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (rd_fire) begin
        if (rd_col == 3'd7) begin
          rd_bank <= ~rd_bank;
          rd_col  <= 3'd0;
        end else begin
          rd_col  <= rd_col + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for dct_transpose_buf: accepted rows build expected columns,
// a monitor thread pops and compares every accepted output beat.
module tb_dct_transpose_buf;
  localparam int W_D = 16;

  typedef struct packed {
    logic [7:0][W_D-1:0] data;
    logic [2:0]          col;
    logic                last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic signed [7:0][W_D-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic signed [7:0][W_D-1:0] out_data;
  logic [2:0] out_col;
  logic out_last;

  int total = 0;
  int bad = 0;
  beat_t q[$];
  logic [7:0][W_D-1:0] mrow [8];
  int m_row = 0;
  int cyc = 0;
  int beats = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int stalls = 0;
  bit rnd_on = 1'b0;

  always #5 clk = ~clk;

  dct_transpose_buf #(.W_D(W_D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .out_last(out_last)
  );

  task automatic chk(input string name, input logic [8*W_D-1:0] act, input logic [8*W_D-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W_D-1:0] val(input int k, input int r, input int j);
    return W_D'(100 * k + 8 * r + j);
  endfunction

  function automatic logic [7:0][W_D-1:0] mkrow(input int k, input int r);
    logic [7:0][W_D-1:0] row;
    for (int j = 0; j < 8; j++) row[j] = val(k, r, j);
    return row;
  endfunction

  // Accepted row goes into the model; a completed block yields 8 expected columns.
  task automatic record(input logic [7:0][W_D-1:0] row);
    beat_t b;
    mrow[m_row] = row;
    m_row++;
    if (m_row == 8) begin
      for (int c = 0; c < 8; c++) begin
        for (int i = 0; i < 8; i++) b.data[i] = mrow[i][c];
        b.col  = 3'(c);
        b.last = (c == 7);
        q.push_back(b);
      end
      m_row = 0;
    end
  endtask

  // Entered and left at posedge+1; holds in_valid until the row is taken.
  task automatic send_row(input logic [7:0][W_D-1:0] row);
    int n = 0;
    in_valid = 1'b1;
    in_data  = row;
    @(negedge clk);
    if (!in_ready) stalls++;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_row_timeout: in_ready got 0 expected 1 within 2000 cycles");
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      record(row);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 128'(q.size()), 128'd0);
    @(posedge clk); #1;
    chk("idle_after_drain", out_valid, 1'b0);
  endtask

  initial begin
    logic [7:0][W_D-1:0] row;
    logic [7:0][W_D-1:0] col0;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (rst_n && out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got col %0d expected no beat", out_col);
          end else begin
            beat_t b;
            b = q.pop_front();
            chk("col_data", out_data, b.data);
            chk("col_idx", out_col, b.col);
            chk("col_last", out_last, b.last);
          end
          beats++;
          if (beats == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
    join_none

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_col", out_col, 3'd0);
    chk("rst_out_last", out_last, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single block: column 0 appears right after row 7 is written.
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if (r == 7) chk("single_not_early", out_valid, 1'b0);
      send_row(mkrow(0, r));
    end
    chk("single_latency", out_valid, 1'b1);
    chk("single_col0", out_data, q[0].data);
    drain();

    // Streaming: four blocks back to back, continuous output.
    beats = 0; stalls = 0;
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < 8; r++) send_row(mkrow(k, r));
    drain();
    chk("stream_no_stall", 128'(stalls), 128'd0);
    chk("stream_beats", 128'(beats), 128'd32);
    chk("stream_contig", 128'(last_cyc - first_cyc), 128'd31);

    // Backpressure: both banks fill, then the drain frees one.
    out_ready = 1'b0;
    for (int k = 10; k < 12; k++)
      for (int r = 0; r < 8; r++) send_row(mkrow(k, r));
    for (int i = 0; i < 8; i++) col0[i] = val(10, i, 0);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    row = mkrow(12, 0);
    in_valid = 1'b1; in_data = row;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_blocked", in_ready, 1'b0);
    chk("bp_frozen_data", out_data, col0);
    chk("bp_frozen_col", out_col, 3'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_hold_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    chk("bp_ready_back", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    record(row);
    for (int r = 1; r < 8; r++) send_row(mkrow(12, r));
    drain();

    // Sign extremes.
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 8; j++) row[j] = ((r + j) % 2 == 1) ? 16'sh7FFF : 16'sh8000;
      send_row(row);
    end
    drain();

    // Gapped input with random downstream stalls.
    beats = 0;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          if (rnd_on) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join_none
    for (int k = 0; k < 20; k++) begin
      for (int r = 0; r < 8; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk); #1;
        end
        for (int j = 0; j < 8; j++) row[j] = W_D'($urandom);
        send_row(row);
      end
    end
    begin
      int n = 0;
      while (q.size() != 0 && n < 5000) begin
        @(negedge clk);
        n++;
      end
    end
    rnd_on = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();
    chk("rand_beats", 128'(beats), 128'd160);

    // Reset mid-operation: block 0 draining at column 3, block 1 at row 4.
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row(mkrow(30, r));
    for (int r = 0; r < 5; r++) send_row(mkrow(31, r));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("mid_col3", out_col, 3'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_data", out_data, '0);
    chk("mid_rst_out_col", out_col, 3'd0);
    q.delete();
    m_row = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) send_row(mkrow(40, r));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
